// File: rtl/axil_pkg.sv
// Shared response codes and read-path state encoding for the AXI-lite register slave.
package axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;
endpackage

// File: rtl/axil_regfile.sv
// NUM_REGS x DATA_WD register array: one byte-strobed write port, one combinational read port.
// Addresses at or above NUM_REGS read as zero, ignore writes and report in_range low.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int ADDR_WD  = 8,
  parameter int DATA_WD  = 8,
  parameter int NUM_REGS = 16,
  parameter int STRB_WD  = DATA_WD / 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               we,
  input  logic [ADDR_WD-1:0] waddr,
  input  logic [DATA_WD-1:0] wdata,
  input  logic [STRB_WD-1:0] wstrb,
  output logic               w_in_range,
  input  logic [ADDR_WD-1:0] raddr,
  output logic [DATA_WD-1:0] rdata,
  output logic               r_in_range
);

  logic [DATA_WD-1:0] regs [NUM_REGS];

  // One extra bit so NUM_REGS == 2**ADDR_WD still compares correctly.
  assign w_in_range = ({1'b0, waddr} < (ADDR_WD+1)'(NUM_REGS));
  assign r_in_range = ({1'b0, raddr} < (ADDR_WD+1)'(NUM_REGS));

  // Byte-strobed write into the addressed register; out-of-range addresses match no entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (waddr == ADDR_WD'(i)) begin
          for (int b = 0; b < STRB_WD; b++) begin
            if (wstrb[b]) regs[i][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Address decode by compare, so an out-of-range index never indexes past the array.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr == ADDR_WD'(i)) rdata = regs[i];
    end
  end

endmodule

// File: rtl/axil_slave_regs.sv
// AXI-lite slave register bank. Write path holds AW and W independently and commits once
// both are held; read path is a two-state FSM. One write and one read outstanding at most.
module axil_slave_regs
  import axil_pkg::*;
#(
  parameter int ADDR_WD  = 8,
  parameter int DATA_WD  = 8,
  parameter int NUM_REGS = 16,
  localparam int STRB_WD = DATA_WD / 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [ADDR_WD-1:0] awaddr,
  input  logic               awvalid,
  output logic               awready,
  input  logic [DATA_WD-1:0] wdata,
  input  logic [STRB_WD-1:0] wstrb,
  input  logic               wvalid,
  output logic               wready,
  output logic [1:0]         bresp,
  output logic               bvalid,
  input  logic               bready,
  input  logic [ADDR_WD-1:0] araddr,
  input  logic               arvalid,
  output logic               arready,
  output logic [DATA_WD-1:0] rdata,
  output logic [1:0]         rresp,
  output logic               rvalid,
  input  logic               rready
);

  logic               en_q;
  logic               aw_held, w_held, commit;
  logic [ADDR_WD-1:0] awaddr_q;
  logic [DATA_WD-1:0] wdata_q;
  logic [STRB_WD-1:0] wstrb_q;
  logic               w_in_range, r_in_range;
  logic [DATA_WD-1:0] rf_rdata;
  logic               ar_fire;
  rstate_e            state_q, state_d;

  assign awready = en_q & ~aw_held & ~bvalid;
  assign wready  = en_q & ~w_held & ~bvalid;
  assign commit  = aw_held & w_held;

  axil_regfile #(
    .ADDR_WD (ADDR_WD),
    .DATA_WD (DATA_WD),
    .NUM_REGS(NUM_REGS),
    .STRB_WD (STRB_WD)
  ) u_regfile (
    .clk       (clk),
    .rstn      (rstn),
    .we        (commit),
    .waddr     (awaddr_q),
    .wdata     (wdata_q),
    .wstrb     (wstrb_q),
    .w_in_range(w_in_range),
    .raddr     (araddr),
    .rdata     (rf_rdata),
    .r_in_range(r_in_range)
  );

  // Readies come up one edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) en_q <= 1'b0;
    else       en_q <= 1'b1;
  end

  // Write path: hold AW/W separately, commit when both held, then hold B until accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= w_in_range ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (awvalid && awready) begin
          aw_held  <= 1'b1;
          awaddr_q <= awaddr;
        end
        if (wvalid && wready) begin
          w_held  <= 1'b1;
          wdata_q <= wdata;
          wstrb_q <= wstrb;
        end
        if (bvalid && bready) bvalid <= 1'b0;
      end
    end
  end

  // Read FSM next state and handshake outputs; arready is computed before use to avoid a loop.
  always_comb begin
    state_d = state_q;
    arready = en_q & (state_q == R_IDLE);
    rvalid  = (state_q == R_DATA);
    ar_fire = arvalid & arready;
    if (ar_fire)                              state_d = R_DATA;
    else if (state_q == R_DATA && rready)     state_d = R_IDLE;
  end

  // Read FSM state register and captured read data (sampled before a same-edge write lands).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= R_IDLE;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (ar_fire) begin
        rdata <= rf_rdata;
        rresp <= r_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axil_slave_regs.sv
// Directed + random-backpressure bench for axil_slave_regs; scoreboard queues checked by a monitor.
module tb_axil_slave_regs;
  localparam int NR = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] awaddr = '0;
  logic       awvalid = 1'b0;
  logic       awready;
  logic [7:0] wdata = '0;
  logic [0:0] wstrb = '0;
  logic       wvalid = 1'b0;
  logic       wready;
  logic [1:0] bresp;
  logic       bvalid;
  logic       bready;
  logic [7:0] araddr = '0;
  logic       arvalid = 1'b0;
  logic       arready;
  logic [7:0] rdata;
  logic [1:0] rresp;
  logic       rvalid;
  logic       rready;

  logic rand_bp = 1'b0, bready_force = 1'b1, rready_force = 1'b1;
  logic bp_b = 1'b1, bp_r = 1'b1;
  assign bready = rand_bp ? bp_b : bready_force;
  assign rready = rand_bp ? bp_r : rready_force;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] resp;
  } rexp_t;

  logic [1:0] bq [$];
  rexp_t      rq [$];
  logic [7:0] mdl [NR];
  logic [1:0] mon_eb;
  rexp_t      mon_er;
  int nvec = 0, nerr = 0;

  axil_slave_regs dut (
    .clk(clk), .rstn(rstn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    bp_b = 1'($urandom_range(0, 1));
    bp_r = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", nvec);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] resp_of(input logic [7:0] a);
    return (a < NR) ? 2'b00 : 2'b10;
  endfunction

  // Monitor: compare every B/R handshake against the head of its scoreboard queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("unexpected_b", 1, 0);
        else begin
          mon_eb = bq.pop_front();
          chk("bresp", bresp, mon_eb);
        end
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) chk("unexpected_r", 1, 0);
        else begin
          mon_er = rq.pop_front();
          chk("rdata_rresp", {rdata, rresp}, {mon_er.data, mon_er.resp});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after both AW and W have fired.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic s,
                          input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, af, wf;
    int cyc = 0;
    bq.push_back(resp_of(a));
    if (a < NR && s) mdl[a] = d;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 64) begin
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid  = !w_done && cyc >= w_dly;
      @(negedge clk);
      af = awvalid && awready;
      wf = wvalid && wready;
      @(posedge clk); #1;
      if (af) aw_done = 1;
      if (wf) w_done = 1;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    chk("aw_w_accepted", {30'd0, aw_done, w_done}, 3);
  endtask

  task automatic do_read(input logic [7:0] a, input int dly);
    bit done = 0, f;
    int cyc = 0;
    rexp_t e;
    e.data = (a < NR) ? mdl[a] : 8'h00;
    e.resp = resp_of(a);
    rq.push_back(e);
    araddr = a;
    while (!done && cyc < 64) begin
      arvalid = cyc >= dly;
      @(negedge clk);
      f = arvalid && arready;
      @(posedge clk); #1;
      if (f) done = 1;
      cyc++;
    end
    arvalid = 0;
    chk("ar_accepted", {31'd0, done}, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("queues_drained", bq.size() + rq.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) mdl[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_readies", {awready, wready, arready}, 0);
    chk("rst_valids", {bvalid, rvalid}, 0);
    chk("rst_data", {rdata, rresp, bresp}, 0);
    @(posedge clk); #1;
    rstn = 1;
    @(negedge clk);
    chk("en_q_not_yet", {awready, wready, arready}, 0);
    @(negedge clk);
    chk("en_q_readies", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;

    // 1: AW+W same cycle, B two cycles after presentation
    awaddr = 8'h03; wdata = 8'hA5; wstrb = 1; awvalid = 1; wvalid = 1;
    bq.push_back(2'b00); mdl[3] = 8'hA5;
    @(negedge clk); chk("t1_ready", {awready, wready}, 2'b11);
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    @(negedge clk); chk("t1_bvalid_c1", bvalid, 0);
    @(negedge clk); chk("t1_bvalid_c2", bvalid, 1);
    @(posedge clk); #1;
    wait_done();
    do_read(8'h03, 0); wait_done();
    // strobe off: no change, OKAY
    do_write(8'h03, 8'hFF, 1'b0, 0, 0); wait_done();
    do_read(8'h03, 1); wait_done();

    // 2: W two cycles before AW
    wdata = 8'h3C; wstrb = 1; wvalid = 1;
    bq.push_back(2'b00); mdl[5] = 8'h3C;
    @(negedge clk); chk("t2_wready", wready, 1);
    @(posedge clk); #1; wvalid = 0;
    @(negedge clk); chk("t2_w_held", wready, 0);
    @(posedge clk); #1; awaddr = 8'h05; awvalid = 1;
    @(negedge clk); chk("t2_w_held_aw_rdy", {wready, awready}, 2'b01);
    @(posedge clk); #1; awvalid = 0;
    wait_done();
    do_read(8'h05, 0); wait_done();

    // 3: out of range and edges of the range
    do_write(8'h20, 8'h5A, 1'b1, 1, 0); wait_done();
    do_read(8'h20, 0); wait_done();
    do_read(8'h00, 0); wait_done();
    do_write(8'h0F, 8'hC3, 1'b1, 0, 2); wait_done();
    do_read(8'h0F, 0); wait_done();
    do_read(8'h10, 0); wait_done();
    do_write(8'hFF, 8'h01, 1'b1, 0, 0); wait_done();

    // 4: B and R backpressure
    bready_force = 0;
    do_write(8'h02, 8'h77, 1'b1, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_b_stall", {bvalid, bresp, awready, wready}, 5'b1_00_00);
    end
    @(posedge clk); #1; bready_force = 1;
    wait_done();
    rready_force = 0;
    do_read(8'h02, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_r_stall", {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, 2'b00, 8'h77});
    end
    @(posedge clk); #1; rready_force = 1;
    wait_done();

    // 5: read and write commit on the same edge -> old value
    awaddr = 8'h07; wdata = 8'h11; wstrb = 1; awvalid = 1; wvalid = 1;
    bq.push_back(2'b00);
    @(negedge clk); chk("t5_ready", {awready, wready}, 2'b11);
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    araddr = 8'h07; arvalid = 1;
    rq.push_back('{data: 8'h00, resp: 2'b00});
    mdl[7] = 8'h11;
    @(negedge clk); chk("t5_arready", arready, 1);
    @(posedge clk); #1; arvalid = 0;
    wait_done();
    do_read(8'h07, 0); wait_done();

    // 6: reset with AW held and rvalid high
    rready_force = 0;
    do_read(8'h01, 0);
    awaddr = 8'h04; awvalid = 1;
    @(negedge clk); chk("t6_aw_ready", {awready, rvalid}, 2'b11);
    @(posedge clk); #1; awvalid = 0;
    #2 rstn = 0;
    #1 chk("t6_rst_outputs", {bvalid, rvalid, awready, wready, arready}, 0);
    bq.delete(); rq.delete();
    for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
    rready_force = 1;
    @(posedge clk); #1; rstn = 1;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      do_read(8'(i), 0); wait_done();
    end

    // Random backpressure, one transaction at a time against the model
    rand_bp = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(8'($urandom_range(0, 19)), 8'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(8'($urandom_range(0, 19)), $urandom_range(0, 3));
      wait_done();
    end
    rand_bp = 0;
    for (int i = 0; i < NR; i++) begin
      do_read(8'(i), 0); wait_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
